apb_uart_rx: RTL and testbench

Receive-side counterpart of the APB-to-UART transmit chain: samples an 8N1 serial line, buffers received bytes in an 8-entry FIFO and returns them to an APB master as read data. It sits behind the same `apb_master` that drives the transmit slave, giving the read path (`prdata`) a real data source. It also exposes sticky line-error status and a not-empty interrupt.

---
 rtl/apb_uart_rx.sv | 210 +++++++++++++++++++++
 tb/tb_apb_uart_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_rx.sv
// apb_uart_rx: 8N1 UART receiver with an 8-entry byte FIFO, read back over APB.
// Ports: pclk/rst (sync, active-high); i_Rx_Serial async line; APB slave
// (psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr);
// o_Rx_Active = frame in progress; o_irq = FIFO not empty (registered).
module apb_uart_rx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        i_Rx_Serial,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        o_Rx_Active,
    output logic        o_irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DEPTH4  = 4'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_t;

    state_t state, nxt;

    logic          sync1, rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          half_done, bit_done;
    logic          active, sample, push, ferr_set;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [3:0]    count;
    logic          full, empty, wr_en, pop, ovr_set;
    logic          ovr, ferr;

    logic          setup, acc, addr_data, addr_stat, bad, w1c;
    logic          pop_arm;
    logic [31:0]   rd_val;
    logic          unused_bits;

    assign unused_bits = ^{paddr[31:4], pwdata[31:8], pwdata[5:0]};

    // Two-flop synchronizer, idle-high reset so reset never looks like a start bit.
    always_ff @(posedge pclk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= i_Rx_Serial;
            rx_s  <= sync1;
        end
    end

    assign half_done = (cnt == HALF_M1);
    assign bit_done  = (cnt == BIT_M1);

    // FSM: state register
    always_ff @(posedge pclk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // FSM: next state
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (!rx_s) nxt = START;
            START:   if (half_done) nxt = rx_s ? IDLE : DATA;
            DATA:    if (bit_done && bit_idx == 3'd7) nxt = STOP;
            STOP:    if (bit_done) nxt = CLEANUP;
            CLEANUP: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        active   = 1'b0;
        sample   = 1'b0;
        push     = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            START: active = 1'b1;
            DATA: begin
                active = 1'b1;
                sample = bit_done;
            end
            STOP: begin
                active   = 1'b1;
                push     = bit_done & rx_s;
                ferr_set = bit_done & ~rx_s;
            end
            default: ;
        endcase
    end

    assign o_Rx_Active = active;

    // Receive datapath: cycle counter, bit index, shift register
    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            unique case (state)
                START:     cnt <= half_done ? '0 : cnt + 1'b1;
                DATA, STOP: cnt <= bit_done ? '0 : cnt + 1'b1;
                default:   cnt <= '0;
            endcase
            if (state == IDLE) bit_idx <= '0;
            else if (sample)   bit_idx <= bit_idx + 1'b1;
            if (sample) shreg <= {rx_s, shreg[7:1]};
        end
    end

    // APB decode
    assign setup     = psel & ~penable;
    assign acc       = psel & penable;
    assign addr_data = (paddr[3:0] == 4'h0);
    assign addr_stat = (paddr[3:0] == 4'h4);
    assign bad       = ~(addr_data | addr_stat) | (pwrite & addr_data);
    assign w1c       = acc & pwrite & addr_stat;
    assign pready    = acc;
    assign pslverr   = acc & bad;

    // FIFO control; a pop frees the slot a same-cycle push needs.
    assign full    = (count == DEPTH4);
    assign empty   = (count == 4'd0);
    assign pop     = acc & pop_arm;
    assign wr_en   = push & (~full | pop);
    assign ovr_set = push & full & ~pop;

    always_ff @(posedge pclk) begin
        if (wr_en) mem[wptr] <= shreg;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            if (wr_en && !pop)      count <= count + 4'd1;
            else if (!wr_en && pop) count <= count - 4'd1;
        end
    end

    // Sticky errors: a set in the same cycle as a clear wins.
    always_ff @(posedge pclk) begin
        if (rst) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (ovr_set)               ovr <= 1'b1;
            else if (w1c && pwdata[6]) ovr <= 1'b0;
            if (ferr_set)              ferr <= 1'b1;
            else if (w1c && pwdata[7]) ferr <= 1'b0;
        end
    end

    always_comb begin
        rd_val = '0;
        if (!pwrite && !bad) begin
            if (addr_data)
                rd_val = {23'b0, ~empty, empty ? 8'h00 : mem[rptr]};
            else
                rd_val = {23'b0, active, ferr, ovr, full, empty, count};
        end
    end

    // Read data and the pop decision are both captured in the setup phase,
    // so the popped entry is exactly the one returned.
    always_ff @(posedge pclk) begin
        if (rst) begin
            prdata  <= '0;
            pop_arm <= 1'b0;
        end else if (setup) begin
            prdata  <= rd_val;
            pop_arm <= ~pwrite & addr_data & ~empty;
        end else if (acc) begin
            pop_arm <= 1'b0;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) o_irq <= 1'b0;
        else     o_irq <= ~empty;
    end

endmodule

// File: tb/tb_apb_uart_rx.sv
// tb_apb_uart_rx: directed + randomized bench for apb_uart_rx.
// Expected values come from a queue-based model of the receive FIFO and flags.
module tb_apb_uart_rx;

    localparam int CPB   = 87;
    localparam int DEPTH = 8;

    logic        pclk = 1'b0;
    logic        rst;
    logic        line;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr, o_Rx_Active, o_irq;

    apb_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .pclk(pclk), .rst(rst), .i_Rx_Serial(line),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr),
        .o_Rx_Active(o_Rx_Active), .o_irq(o_irq)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q[$];
    logic       m_ovr, m_ferr;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n = q.size();
        return 32'(n) | ((n == 0) ? 32'h10 : 32'h0) | ((n == DEPTH) ? 32'h20 : 32'h0)
             | (m_ovr ? 32'h40 : 32'h0) | (m_ferr ? 32'h80 : 32'h0);
    endfunction

    function automatic logic [31:0] exp_pop();
        if (q.size() == 0) return 32'h0;
        return 32'h100 | 32'(q.pop_front());
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (!stop) m_ferr = 1'b1;
        else if (q.size() == DEPTH) m_ovr = 1'b1;
        else q.push_back(b);
    endtask

    // All tasks start and end 1ns after a rising edge.
    task automatic wait_bit();
        repeat (CPB) @(posedge pclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        line = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            wait_bit();
        end
        line = stop;
        wait_bit();
        line = 1'b1;
        if (!stop) wait_bit();
    endtask

    task automatic apb(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic rdy, output logic err);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = {28'h0, a};
        pwdata  = wd;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        #1;
        rd  = prdata;
        rdy = pready;
        err = pslverr;
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    logic [31:0] rd, rd_b, exp_b;
    logic        rdy, err, rdy_b, err_b;
    logic [7:0]  b;
    logic        st;
    int          n;

    task automatic chk_status(input string tag);
        logic [31:0] r;
        logic        y, e;
        apb(1'b0, 4'h4, 32'h0, r, y, e);
        check(tag, r, exp_status());
    endtask

    task automatic chk_read(input string tag);
        logic [31:0] r;
        logic        y, e;
        apb(1'b0, 4'h0, 32'h0, r, y, e);
        check(tag, r, exp_pop());
    endtask

    initial begin
        rst = 1'b1; line = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", {31'b0, pready}, 32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check("rst_active", {31'b0, o_Rx_Active}, 32'h0);
        check("rst_irq", {31'b0, o_irq}, 32'h0);
        rst = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        chk_status("rst_status");

        // Reset during DATA of a truncated 0x5A frame
        b = 8'h5A;
        line = 1'b0;
        wait_bit();
        for (int i = 0; i < 4; i++) begin
            line = b[i];
            wait_bit();
        end
        check("mid_active", {31'b0, o_Rx_Active}, 32'h1);
        line = 1'b1;
        rst = 1'b1;
        @(posedge pclk);
        #1;
        rst = 1'b0;
        q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        check("mid_rst_active", {31'b0, o_Rx_Active}, 32'h0);
        repeat (200) @(posedge pclk);
        #1;
        chk_status("mid_rst_status");
        send_frame(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        chk_read("mid_next_byte");

        // Single byte with latency checks
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (2) @(posedge pclk);
                #1;
                check("lat_active_pre", {31'b0, o_Rx_Active}, 32'h0);
                @(posedge pclk);
                #1;
                check("lat_active_start", {31'b0, o_Rx_Active}, 32'h1);
                repeat (826) @(posedge pclk);
                #1;
                check("lat_irq_push", {31'b0, o_irq}, 32'h0);
                @(posedge pclk);
                #1;
                check("lat_irq_rise", {31'b0, o_irq}, 32'h1);
            end
        join
        model_frame(8'hA5, 1'b1);
        chk_status("single_status");
        apb(1'b0, 4'h0, 32'h0, rd, rdy, err);
        check("single_data", rd, exp_pop());
        check("single_pready", {31'b0, rdy}, 32'h1);
        check("single_pslverr", {31'b0, err}, 32'h0);
        @(posedge pclk);
        #1;
        check("single_irq_fall", {31'b0, o_irq}, 32'h0);
        chk_status("single_status_empty");

        // Overflow: nine back-to-back frames
        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1);
        end
        chk_status("ovf_status");
        for (int i = 0; i < 8; i++) chk_read("ovf_data");
        apb(1'b1, 4'h4, 32'h40, rd, rdy, err);
        m_ovr = 1'b0;
        chk_status("ovf_w1c");

        // Framing error keeps count
        b = 8'($urandom);
        send_frame(b, 1'b1);
        model_frame(b, 1'b1);
        send_frame(8'($urandom), 1'b0);
        model_frame(8'h00, 1'b0);
        repeat (100) @(posedge pclk);
        #1;
        chk_status("ferr_status");
        apb(1'b1, 4'h4, 32'h80, rd, rdy, err);
        m_ferr = 1'b0;
        chk_status("ferr_w1c");
        chk_read("ferr_data");

        // 20-cycle glitch
        line = 1'b0;
        repeat (20) @(posedge pclk);
        #1;
        line = 1'b1;
        repeat (60) @(posedge pclk);
        #1;
        check("glitch_active", {31'b0, o_Rx_Active}, 32'h0);
        chk_status("glitch_status");

        // Push and pop on the same edge with a full FIFO
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1);
            model_frame(b, 1'b1);
        end
        b = 8'($urandom);
        exp_b = 32'h100 | 32'(q[0]);
        fork
            send_frame(b, 1'b1);
            begin
                repeat (827) @(posedge pclk);
                #1;
                apb(1'b0, 4'h0, 32'h0, rd_b, rdy_b, err_b);
            end
        join
        check("simul_data", rd_b, exp_b);
        void'(q.pop_front());
        model_frame(b, 1'b1);
        chk_status("simul_status");
        for (int i = 0; i < DEPTH; i++) chk_read("simul_order");

        // Bus errors
        b = 8'($urandom);
        send_frame(b, 1'b1);
        model_frame(b, 1'b1);
        check("idle_pready", {31'b0, pready}, 32'h0);
        apb(1'b0, 4'h8, 32'h0, rd, rdy, err);
        check("err_rd8_pslverr", {31'b0, err}, 32'h1);
        check("err_rd8_prdata", rd, 32'h0);
        apb(1'b1, 4'h0, 32'hFFFF_FFFF, rd, rdy, err);
        check("err_wr0_pslverr", {31'b0, err}, 32'h1);
        check("err_wr0_prdata", rd, 32'h0);
        chk_status("err_status");
        chk_read("err_data");
        apb(1'b0, 4'h0, 32'h0, rd, rdy, err);
        check("empty_prdata", rd, 32'h0);
        check("empty_pslverr", {31'b0, err}, 32'h0);
        check("empty_pready", {31'b0, rdy}, 32'h1);

        // Randomized rounds
        for (int r = 0; r < 2; r++) begin
            n = $urandom_range(3, 10);
            for (int i = 0; i < n; i++) begin
                b  = 8'($urandom);
                st = ($urandom_range(0, 5) != 0);
                send_frame(b, st);
                model_frame(b, st);
            end
            chk_status("rnd_status");
            n = q.size();
            for (int i = 0; i < n; i++) chk_read("rnd_data");
            apb(1'b1, 4'h4, 32'hC0, rd, rdy, err);
            m_ovr = 1'b0;
            m_ferr = 1'b0;
            chk_status("rnd_clear");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
